// File: rtl/music_pkg.sv
// Shared note-interface definitions for the music engine: code widths, rest code,
// FSM states and the elaboration-time half-period calculation.
package music_pkg;

    localparam int unsigned NOTE_W = 5;
    localparam int unsigned NUM_NOTES = 25;
    localparam logic [NOTE_W-1:0] REST_CODE = 5'd25;

    typedef enum logic {
        IDLE,
        PLAY
    } state_e;

    // 2^(semi/12) for one octave, in Q16 fixed point.
    function automatic longint unsigned semitone_ratio_q16(input int unsigned semi);
        case (semi)
            0:       return 64'd65536;
            1:       return 64'd69433;
            2:       return 64'd73562;
            3:       return 64'd77935;
            4:       return 64'd82570;
            5:       return 64'd87480;
            6:       return 64'd92682;
            7:       return 64'd98193;
            8:       return 64'd104032;
            9:       return 64'd110218;
            10:      return 64'd116772;
            11:      return 64'd123715;
            default: return 64'd65536;
        endcase
    endfunction

    // round(clk_hz / (440 * 2^(note/12))), clamped to 2; rest codes give 0.
    function automatic int unsigned half_period(input int unsigned note, input int unsigned clk_hz);
        longint unsigned num;
        longint unsigned den;
        longint unsigned q;
        if (note >= NUM_NOTES) begin
            return 0;
        end
        num = 64'(clk_hz) << 16;
        den = (64'(440) * semitone_ratio_q16(note % 12)) << (note / 12);
        q = ((num << 1) + den) / (den << 1);
        if (q < 64'd2) begin
            q = 64'd2;
        end
        return 32'(q);
    endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Note interface between the song sequencer (master) and the tone generator (slave).
interface tone_synth_if;
    import music_pkg::*;

    logic [NOTE_W-1:0] note_in;
    logic              mute;
    logic              tone_out;
    logic              playing;
    logic [NOTE_W-1:0] cur_note;

    modport master (
        output note_in,
        output mute,
        input  tone_out,
        input  playing,
        input  cur_note
    );

    modport slave (
        input  note_in,
        input  mute,
        output tone_out,
        output playing,
        output cur_note
    );

endinterface

// File: rtl/note_period_rom.sv
// Constant lookup from note code to half-period in clock cycles; rest codes read 0.
module note_period_rom
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned CNT_W  = 17
) (
    input  logic [NOTE_W-1:0] code,
    output logic [CNT_W-1:0]  half
);

    logic [CNT_W-1:0] period_tbl [2**NOTE_W];

    for (genvar g = 0; g < 2**NOTE_W; g++) begin : g_entry
        localparam int unsigned HP = half_period(g, CLK_HZ);
        assign period_tbl[g] = CNT_W'(HP);
    end

    assign half = period_tbl[code];

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator: 50 % duty, pitch and mute applied only at full-period
// boundaries so the speaker output never produces runt pulses.
module tone_synth
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned CNT_W  = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_synth_if.slave   bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tone_q, tone_d;
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;

    logic              note_valid;
    logic [NOTE_W-1:0] rom_addr;
    logic [CNT_W-1:0]  rom_half;

    assign note_valid = (bus.note_in < NOTE_W'(NUM_NOTES)) && !bus.mute;

    // The mid-period reload keeps the sounding pitch; every other load takes the new code.
    assign rom_addr = (state_q == PLAY && tone_q) ? cur_note_q : bus.note_in;

    note_period_rom #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_rom (
        .code (rom_addr),
        .half (rom_half)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tone_d     = tone_q;
        cur_note_d = cur_note_q;
        case (state_q)
            IDLE: begin
                tone_d     = 1'b0;
                cnt_d      = '0;
                cur_note_d = REST_CODE;
                if (note_valid) begin
                    state_d    = PLAY;
                    tone_d     = 1'b1;
                    cur_note_d = bus.note_in;
                    cnt_d      = rom_half - CNT_W'(1);
                end
            end
            PLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (tone_q) begin
                    tone_d = 1'b0;
                    cnt_d  = rom_half - CNT_W'(1);
                end else if (note_valid) begin
                    tone_d     = 1'b1;
                    cur_note_d = bus.note_in;
                    cnt_d      = rom_half - CNT_W'(1);
                end else begin
                    state_d    = IDLE;
                    tone_d     = 1'b0;
                    cur_note_d = REST_CODE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tone_q     <= 1'b0;
            cur_note_q <= REST_CODE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tone_q     <= tone_d;
            cur_note_q <= cur_note_d;
        end
    end

    assign bus.tone_out = tone_q;
    assign bus.playing  = (state_q == PLAY);
    assign bus.cur_note = cur_note_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth at CLK_HZ = 44_000 (half periods: 0->100, 3->84,
// 7->67, 12->50, 14->45, 24->25).
module tb_tone_synth;

    typedef struct {
        logic [4:0]  note;
        logic        mute;
        int unsigned half;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int unsigned checks = 0;
    int unsigned errors = 0;

    tone_synth_if bus ();

    tone_synth #(
        .CLK_HZ (44_000),
        .CNT_W  (17)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] n, input logic m);
        bus.note_in = n;
        bus.mute    = m;
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Counts consecutive sampled cycles with tone_out == lvl while playing.
    task automatic measure(input logic lvl, output int unsigned len);
        len = 0;
        while (bus.tone_out === lvl && bus.playing === 1'b1 && len < 400) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_tone"}, 32'(bus.tone_out), 0);
        check({name, "_playing"}, 32'(bus.playing), 0);
        check({name, "_cur"}, 32'(bus.cur_note), 25);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [8];
        int unsigned len;
        int unsigned busy;

        vecs[0] = '{5'd0,  1'b0, 100};
        vecs[1] = '{5'd3,  1'b0, 84};
        vecs[2] = '{5'd7,  1'b0, 67};
        vecs[3] = '{5'd12, 1'b0, 50};
        vecs[4] = '{5'd24, 1'b0, 25};
        vecs[5] = '{5'd25, 1'b0, 0};
        vecs[6] = '{5'd31, 1'b0, 0};
        vecs[7] = '{5'd7,  1'b1, 0};

        // Reset release with note 12 already present
        rst_n = 1'b0;
        drive(5'd12, 1'b0);
        step(2);
        check_idle("reset");
        rst_n = 1'b1;
        step(1);
        check("start_tone", 32'(bus.tone_out), 1);
        check("start_playing", 32'(bus.playing), 1);
        check("start_cur", 32'(bus.cur_note), 12);
        measure(1'b1, len); check("n12_high", len, 50);
        measure(1'b0, len); check("n12_low", len, 50);

        // 12 -> 24 in mid-high phase: period completes, then the new pitch
        step(10);
        drive(5'd24, 1'b0);
        measure(1'b1, len); check("chg_high_rest", len, 40);
        check("chg_cur_hold", 32'(bus.cur_note), 12);
        measure(1'b0, len); check("chg_low", len, 50);
        check("chg_cur_new", 32'(bus.cur_note), 24);
        measure(1'b1, len); check("n24_high", len, 25);
        measure(1'b0, len); check("n24_low", len, 25);
        drive(5'd25, 1'b0);
        measure(1'b1, len); check("n24_end_high", len, 25);
        measure(1'b0, len); check("n24_end_low", len, 25);
        check_idle("chg_end");

        // Table: start from IDLE, two periods, rest at the second period
        foreach (vecs[i]) begin
            drive(vecs[i].note, vecs[i].mute);
            step(1);
            if (vecs[i].half == 0) begin
                step(3);
                check_idle($sformatf("v%0d_nostart", i));
            end else begin
                check($sformatf("v%0d_lat", i), 32'(bus.tone_out), 1);
                check($sformatf("v%0d_cur", i), 32'(bus.cur_note), 32'(vecs[i].note));
                measure(1'b1, len); check($sformatf("v%0d_high", i), len, vecs[i].half);
                measure(1'b0, len); check($sformatf("v%0d_low", i), len, vecs[i].half);
                drive(5'd25, 1'b0);
                measure(1'b1, len); check($sformatf("v%0d_high2", i), len, vecs[i].half);
                measure(1'b0, len); check($sformatf("v%0d_low2", i), len, vecs[i].half);
                check_idle($sformatf("v%0d_end", i));
            end
            drive(5'd25, 1'b0);
            step(2);
        end

        // Sequencer pattern 14, 25 (long), 14: two bursts with a silent gap
        drive(5'd14, 1'b0);
        step(1);
        measure(1'b1, len); check("b1_high", len, 45);
        drive(5'd25, 1'b0);
        measure(1'b0, len); check("b1_low", len, 45);
        check_idle("b1_end");
        busy = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.tone_out !== 1'b0 || bus.playing !== 1'b0) busy++;
            step(1);
        end
        check("gap_silent", busy, 0);
        drive(5'd14, 1'b0);
        step(1);
        check("b2_start", 32'(bus.tone_out), 1);
        measure(1'b1, len); check("b2_high", len, 45);
        // 10-cycle rest inside the low phase is not audible
        step(5);
        drive(5'd25, 1'b0);
        step(10);
        drive(5'd14, 1'b0);
        measure(1'b0, len); check("short_rest_low", len, 30);
        check("short_rest_cont", 32'(bus.tone_out), 1);
        check("short_rest_playing", 32'(bus.playing), 1);
        drive(5'd25, 1'b0);
        measure(1'b1, len); check("b2_high2", len, 45);
        measure(1'b0, len); check("b2_low2", len, 45);
        check_idle("b2_end");

        // Mute raised mid-high on note 7
        drive(5'd7, 1'b0);
        step(1);
        step(20);
        drive(5'd7, 1'b1);
        measure(1'b1, len); check("mute_high", len, 47);
        measure(1'b0, len); check("mute_low", len, 67);
        check_idle("mute_end");
        step(5);
        check_idle("mute_hold");
        // Mute together with a note change: mute wins
        drive(5'd7, 1'b0);
        step(1);
        check("mc_start", 32'(bus.tone_out), 1);
        step(10);
        drive(5'd12, 1'b1);
        measure(1'b1, len); check("mc_high", len, 57);
        measure(1'b0, len); check("mc_low", len, 67);
        check_idle("mc_end");
        drive(5'd25, 1'b0);
        step(2);

        // Asynchronous reset mid-high, then restart on note 3
        drive(5'd7, 1'b0);
        step(11);
        #2 rst_n = 1'b0;
        #1 check_idle("arst");
        drive(5'd3, 1'b0);
        step(2);
        check_idle("arst_hold");
        rst_n = 1'b1;
        step(1);
        check("rst_restart", 32'(bus.tone_out), 1);
        check("rst_restart_cur", 32'(bus.cur_note), 3);
        measure(1'b1, len); check("rst_high", len, 84);
        measure(1'b0, len); check("rst_low", len, 84);
        drive(5'd25, 1'b0);
        measure(1'b1, len); check("rst_high2", len, 84);
        measure(1'b0, len); check("rst_low2", len, 84);
        check_idle("rst_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
